// File: rtl/ohr_mod7_encoder.sv
// Binary to one-hot mod-7 residue encoder, one 3-bit group per cycle (8 == 1 mod 7).
// Latency: operand captured at edge T, out_valid high after edge T+ceil(W/3); one operand in flight.
// Backpressure: in_ready low while converting or holding a result; result held until out_ready.
module ohr_mod7_encoder #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [6:0]   out_res,
    output logic         busy
);

    // Number of 3-bit groups; the top group is zero-padded when W is not a multiple of 3.
    localparam int NG = (W + 2) / 3;
    // Counter width; NG can be 1 when W=3, which still needs a one-bit counter.
    localparam int CW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [CW-1:0] LAST_GRP = CW'(NG - 1);
    // One-hot encoding of residue 0, the starting point of every conversion.
    localparam logic [6:0] ACC_ONE = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  shreg_q;
    logic [W-1:0]  shreg_d;
    logic [6:0]    acc_q;
    logic [6:0]    acc_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]    grp;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic [6:0]    out_res_q;

    // Rotate a one-hot residue left by g (mod 7). g=7 is a full turn and leaves it unchanged.
    // Doubling the word makes the wrap-around fall out of a plain shift.
    function automatic logic [6:0] rotl7(input logic [6:0] v, input logic [2:0] g);
        logic [13:0] dbl;
        logic [13:0] sh;
        dbl = {v, v};
        sh  = dbl << g;
        if (g == 3'd7) begin
            return v;
        end
        return sh[13:7];
    endfunction

    // Datapath next values for one conversion step: fold the low group, drop it, count it.
    always_comb begin
        grp     = shreg_q[2:0];
        acc_d   = rotl7(acc_q, grp);
        shreg_d = shreg_q >> 3;
        cnt_d   = cnt_q + 1'b1;
    end

    // Control FSM with registered handshake outputs; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            acc_q       <= ACC_ONE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_res_q   <= 7'b0000000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg_q    <= in_bin;
                        acc_q      <= ACC_ONE;
                        cnt_q      <= '0;
                        state_q    <= S_CONV;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_CONV: begin
                    acc_q   <= acc_d;
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_d;
                    if (cnt_q == LAST_GRP) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_res_q   <= acc_d;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        out_res_q   <= 7'b0000000;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    acc_q       <= ACC_ONE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    out_res_q   <= 7'b0000000;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_res   = out_res_q;

endmodule

// File: tb/tb_ohr_mod7_encoder.sv
// Testbench for ohr_mod7_encoder: directed residue vectors, backpressure, reset, random traffic.
// Latency: not applicable.
// Backpressure: bench drives out_ready directly, including long stalls.
module tb_ohr_mod7_encoder;

    localparam int W  = 16;
    localparam int NG = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_bin;
    logic         out_valid;
    logic         out_ready;
    logic [6:0]   out_res;
    logic         busy;

    int tests_run    = 0;
    int tests_failed = 0;
    bit mon_en       = 1'b0;

    ohr_mod7_encoder #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] oh7(input logic [31:0] x);
        logic [31:0] r;
        r = x % 7;
        return 7'(7'd1 << r);
    endfunction

    // Reference one-hot mod-7 adder: rotate a by the index of b's set bit.
    function automatic logic [6:0] add_oh(input logic [6:0] a, input logic [6:0] b);
        logic [6:0] res;
        int r;
        r   = 0;
        res = a;
        for (int k = 0; k < 7; k++) begin
            if (b[k]) r = k;
        end
        for (int k = 0; k < r; k++) begin
            res = {res[5:0], res[6]};
        end
        return res;
    endfunction

    // Protocol monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("p_excl", 32'(in_ready && out_valid), 32'd0);
            if (out_valid) check("p_onehot", $countones(out_res), 32'd1);
            else           check("p_zero", 32'(out_res), 32'd0);
        end
    end

    task automatic run_op(input string tag, input logic [15:0] x, input logic [6:0] exp);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_bin    = x;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_bin   = 16'hDEAD;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 1;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(NG + 1));
        check({tag, "_res"}, 32'(out_res), 32'(exp));
        tick();
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    logic [15:0] xq[$];
    logic [15:0] xx;
    logic [15:0] prev_x;
    logic [6:0]  prev_res;
    bit          have_prev;
    int          acc_n;
    int          out_n;
    int          n;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_rdy",  32'(in_ready),  32'd1);
        check("rst_vld",  32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy),      32'd0);
        check("rst_res",  32'(out_res),   32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset beats a simultaneous in_valid.
        in_valid = 1'b1;
        in_bin   = 16'd9;
        rst      = 1'b1;
        tick();
        check("rstprio_rdy",  32'(in_ready), 32'd1);
        check("rstprio_busy", 32'(busy),     32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;

        run_op("zero", 16'h0000, 7'b0000001);
        run_op("d100", 16'd100,  7'b0000100);
        run_op("ffff", 16'hFFFF, 7'b0000010);
        run_op("h8000", 16'h8000, 7'b0000010);
        run_op("d7",   16'd7,    7'b0000001);

        // Backpressure: result held while out_ready low; in_valid ignored meanwhile.
        in_valid  = 1'b1;
        in_bin    = 16'd13;
        out_ready = 1'b0;
        tick();
        in_bin = 16'd3;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_vld", 32'(out_valid), 32'd1);
            check("bp_res", 32'(out_res),   32'h40);
            check("bp_rdy", 32'(in_ready),  32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_rel_rdy", 32'(in_ready),  32'd1);
        check("bp_rel_vld", 32'(out_valid), 32'd0);

        // Reset in the third conversion cycle abandons the operand.
        in_valid = 1'b1;
        in_bin   = 16'hFFFF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rdy",  32'(in_ready),  32'd1);
        check("mid_vld",  32'(out_valid), 32'd0);
        check("mid_res",  32'(out_res),   32'd0);
        check("mid_busy", 32'(busy),      32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("mid_noout", 32'(out_valid), 32'd0);
        run_op("post_rst", 16'd5, 7'b0100000);

        // Random traffic with scoreboard, then drain.
        acc_n     = 0;
        out_n     = 0;
        have_prev = 1'b0;
        for (int c = 0; c < 6040; c++) begin
            if (c < 6000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_bin    = 16'($urandom);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (in_valid && in_ready) begin
                xq.push_back(in_bin);
                acc_n++;
            end
            if (out_valid && out_ready) begin
                if (xq.size() == 0) begin
                    check("rnd_spurious", 32'd1, 32'd0);
                end else begin
                    xx = xq.pop_front();
                    check("rnd_res", 32'(out_res), 32'(oh7(32'(xx))));
                    if (have_prev)
                        check("rnd_add", 32'(add_oh(prev_res, out_res)),
                              32'(oh7(32'(prev_x) + 32'(xx))));
                    prev_x    = xx;
                    prev_res  = out_res;
                    have_prev = 1'b1;
                end
                out_n++;
            end
            tick();
        end
        check("rnd_count", 32'(out_n), 32'(acc_n));
        check("rnd_empty", 32'(xq.size()), 32'd0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
